// File: rtl/gate_seq_ctrl_pkg.sv
// Shared definitions for the gate test sequencer: FSM state encoding,
// vector-order tables, truth-table constants and the vector-order lookup.
// Optional build macro: GATE_SEQ_GRAY_EN selects gray-code vector order.
package gate_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // Vector order tables, entry k at bits [2k+1:2k], each entry is {a,b}.
   localparam logic [7:0] VEC_ORDER_BIN  = {2'b11, 2'b10, 2'b01, 2'b00};
   localparam logic [7:0] VEC_ORDER_GRAY = {2'b10, 2'b11, 2'b01, 2'b00};

   // Common truth tables, bit index = {a,b}.
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_XOR  = 4'b0110;

   // Map the sweep index onto the {a,b} vector driven at that step.
   function automatic logic [1:0] vec_for_index(input logic [1:0] idx);
      logic [2:0] base;
      base = {idx, 1'b0};
`ifdef GATE_SEQ_GRAY_EN
      return VEC_ORDER_GRAY[base +: 2];
`else
      return VEC_ORDER_BIN[base +: 2];
`endif
   endfunction

endpackage

// File: rtl/gate_seq_ctrl_if.sv
// Bundle of the sequencer's control/status handshake and the cell-facing
// drive/observe signals. master = sequencer side, slave = user/cell side.
interface gate_seq_ctrl_if;
   logic       start;
   logic       busy;
   logic       done;
   logic       pass;
   logic [3:0] fail_vec;
   logic       dut_a;
   logic       dut_b;
   logic       dut_y;

   modport master (
      input  start,
      input  dut_y,
      output busy,
      output done,
      output pass,
      output fail_vec,
      output dut_a,
      output dut_b
   );

   modport slave (
      output start,
      output dut_y,
      input  busy,
      input  done,
      input  pass,
      input  fail_vec,
      input  dut_a,
      input  dut_b
   );
endinterface

// File: rtl/gate_seq_settle_timer.sv
// 4-bit loadable down-counter that times the settle window after each
// vector is applied. Expires while the count sits at 1 so the next state
// can be taken on that same cycle.
module gate_seq_settle_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_i,
   input  logic [3:0] load_val_i,
   input  logic       en_i,
   output logic       expire_o
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   // Next count: load wins, otherwise count down while enabled, stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == 4'd1);

endmodule

// File: rtl/gate_seq_ctrl.sv
// Self-checking sequencer for a 2-input combinational gate cell. Drives the
// four input vectors in turn, waits SETTLE_CYCLES, compares the cell output
// against EXPECT_TT and reports per-vector mismatches plus an overall pass.
// Optional build macro: GATE_SEQ_GRAY_EN (gray-code vector order).
module gate_seq_ctrl
   import gate_seq_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [3:0]  EXPECT_TT     = TT_AND
) (
   input  logic            clk,
   input  logic            rst,
   gate_seq_ctrl_if.master bus
);

   localparam logic [3:0] SETTLE_LD = SETTLE_CYCLES[3:0];

   state_e     state_q, state_d;
   logic [1:0] idx_q,   idx_d;
   logic       a_q,     a_d;
   logic       b_q,     b_d;
   logic       busy_q,  busy_d;
   logic       done_q,  done_d;
   logic       pass_q,  pass_d;
   logic [3:0] fail_q,  fail_d;

   logic       tmr_load_s;
   logic       tmr_en_s;
   logic       tmr_expire_s;
   logic [1:0] vec_s;

   gate_seq_settle_timer u_settle_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load_s),
      .load_val_i (SETTLE_LD),
      .en_i       (tmr_en_s),
      .expire_o   (tmr_expire_s)
   );

   assign vec_s = vec_for_index(idx_q);

   // Next-state and datapath decisions for the sweep FSM.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      a_d        = a_q;
      b_d        = b_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      tmr_load_s = 1'b0;
      tmr_en_s   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_APPLY;
               idx_d   = 2'd0;
               fail_d  = 4'd0;
               pass_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_APPLY: begin
            a_d        = vec_s[1];
            b_d        = vec_s[0];
            tmr_load_s = 1'b1;
            if (SETTLE_LD == 4'd0) begin
               state_d = ST_SAMPLE;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            tmr_en_s = 1'b1;
            if (tmr_expire_s) begin
               state_d = ST_SAMPLE;
            end else begin
               state_d = ST_SETTLE;
            end
         end
         ST_SAMPLE: begin
            // Case inequality so an X/Z cell output also counts as a mismatch.
            if (bus.dut_y !== EXPECT_TT[{a_q, b_q}]) begin
               fail_d[{a_q, b_q}] = 1'b1;
            end else begin
               fail_d = fail_q;
            end
            if (idx_q == 2'd3) begin
               state_d = ST_DONE;
               pass_d  = (fail_d == 4'd0);
            end else begin
               state_d = ST_APPLY;
               idx_d   = idx_q + 2'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
      end
   end

   assign bus.dut_a    = a_q;
   assign bus.dut_b    = b_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.pass     = pass_q;
   assign bus.fail_vec = fail_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl: a default instance (SETTLE_CYCLES=2) and a
// zero-settle instance, each driving a behavioural cell model.
module tb_gate_seq_ctrl;

   logic       clk;
   logic       rst;
   logic [1:0] cell_mode;   // 0 AND, 1 stuck-at-0, 2 OR
   logic       y_m;
   logic       y_z;
   int         n_checks;
   int         n_fail;

`ifdef GATE_SEQ_GRAY_EN
   localparam logic [7:0] EXP_ORDER = {2'b10, 2'b11, 2'b01, 2'b00};
`else
   localparam logic [7:0] EXP_ORDER = {2'b11, 2'b10, 2'b01, 2'b00};
`endif

   gate_seq_ctrl_if m_if ();
   gate_seq_ctrl_if z_if ();

   gate_seq_ctrl #(.SETTLE_CYCLES(2), .EXPECT_TT(4'b1000)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (m_if.master)
   );

   gate_seq_ctrl #(.SETTLE_CYCLES(0), .EXPECT_TT(4'b1000)) u_dut_z (
      .clk (clk),
      .rst (rst),
      .bus (z_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural cell models.
   always_comb begin
      case (cell_mode)
         2'd0:    y_m = m_if.dut_a & m_if.dut_b;
         2'd1:    y_m = 1'b0;
         2'd2:    y_m = m_if.dut_a | m_if.dut_b;
         default: y_m = m_if.dut_a & m_if.dut_b;
      endcase
      case (cell_mode)
         2'd0:    y_z = z_if.dut_a & z_if.dut_b;
         2'd1:    y_z = 1'b0;
         2'd2:    y_z = z_if.dut_a | z_if.dut_b;
         default: y_z = z_if.dut_a & z_if.dut_b;
      endcase
   end

   assign m_if.dut_y = y_m;
   assign z_if.dut_y = y_z;

   // Pulse start on one instance and observe cycles 1..n_cyc after acceptance.
   task automatic run_sweep(input bit sel, input int n_cyc, output int done_cyc,
                            output int done_cnt, output int busy_cnt,
                            output int busy_last, output logic [7:0] vecs);
      logic d;
      logic b;
      done_cyc  = -1;
      done_cnt  = 0;
      busy_cnt  = 0;
      busy_last = 0;
      vecs      = 8'd0;
      @(negedge clk);
      if (sel) z_if.start = 1'b1;
      else     m_if.start = 1'b1;
      @(posedge clk); #1;
      m_if.start = 1'b0;
      z_if.start = 1'b0;
      for (int c = 1; c <= n_cyc; c++) begin
         d = sel ? z_if.done : m_if.done;
         b = sel ? z_if.busy : m_if.busy;
         if (d) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (b) begin
            busy_cnt++;
            busy_last = c;
         end
         if (!sel && (c % 4 == 0) && (c <= 16))
            vecs[(c / 4 - 1) * 2 +: 2] = {m_if.dut_a, m_if.dut_b};
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      m_if.start = 1'b0;
      z_if.start = 1'b0;
      cell_mode = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (m_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", m_if.busy); end
      n_checks++; if (m_if.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", m_if.done); end
      n_checks++; if (m_if.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %b want 0", m_if.pass); end
      n_checks++; if (m_if.fail_vec !== 4'b0000) begin n_fail++; $display("FAIL reset_fail_vec got %b want 0000", m_if.fail_vec); end
      n_checks++; if ({m_if.dut_a, m_if.dut_b} !== 2'b00) begin n_fail++; $display("FAIL reset_ab got %b want 00", {m_if.dut_a, m_if.dut_b}); end
      n_checks++; if (z_if.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_z got %b want 0", z_if.busy); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_and_pass;
      int dc, dn, bc, bl;
      logic [7:0] v;
      cell_mode = 2'd0;
      run_sweep(1'b0, 22, dc, dn, bc, bl, v);
      n_checks++; if (dc !== 17) begin n_fail++; $display("FAIL and_done_cycle got %0d want 17", dc); end
      n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL and_done_pulses got %0d want 1", dn); end
      n_checks++; if (bc !== 17 || bl !== 17) begin n_fail++; $display("FAIL and_busy got count %0d last %0d want 17/17", bc, bl); end
      n_checks++; if (v !== EXP_ORDER) begin n_fail++; $display("FAIL and_vec_order got %b want %b", v, EXP_ORDER); end
      n_checks++; if (m_if.pass !== 1'b1) begin n_fail++; $display("FAIL and_pass got %b want 1", m_if.pass); end
      n_checks++; if (m_if.fail_vec !== 4'b0000) begin n_fail++; $display("FAIL and_fail_vec got %b want 0000", m_if.fail_vec); end
      n_checks++; if ({m_if.dut_a, m_if.dut_b} !== EXP_ORDER[7:6]) begin n_fail++; $display("FAIL and_hold_ab got %b want %b", {m_if.dut_a, m_if.dut_b}, EXP_ORDER[7:6]); end
   endtask

   task automatic test_stuck0;
      int dc, dn, bc, bl;
      logic [7:0] v;
      cell_mode = 2'd1;
      run_sweep(1'b0, 22, dc, dn, bc, bl, v);
      n_checks++; if (dc !== 17) begin n_fail++; $display("FAIL s0_done_cycle got %0d want 17", dc); end
      n_checks++; if (m_if.pass !== 1'b0) begin n_fail++; $display("FAIL s0_pass got %b want 0", m_if.pass); end
      n_checks++; if (m_if.fail_vec !== 4'b1000) begin n_fail++; $display("FAIL s0_fail_vec got %b want 1000", m_if.fail_vec); end
   endtask

   task automatic test_or_cell;
      int dc, dn, bc, bl;
      logic [7:0] v;
      cell_mode = 2'd2;
      run_sweep(1'b0, 22, dc, dn, bc, bl, v);
      n_checks++; if (m_if.pass !== 1'b0) begin n_fail++; $display("FAIL or_pass got %b want 0", m_if.pass); end
      n_checks++; if (m_if.fail_vec !== 4'b0110) begin n_fail++; $display("FAIL or_fail_vec got %b want 0110", m_if.fail_vec); end
      run_sweep(1'b1, 14, dc, dn, bc, bl, v);
      n_checks++; if (dc !== 9) begin n_fail++; $display("FAIL zs_done_cycle got %0d want 9", dc); end
      n_checks++; if (bc !== 9 || bl !== 9) begin n_fail++; $display("FAIL zs_busy got count %0d last %0d want 9/9", bc, bl); end
      n_checks++; if (z_if.fail_vec !== 4'b0110) begin n_fail++; $display("FAIL zs_fail_vec got %b want 0110", z_if.fail_vec); end
      n_checks++; if (z_if.pass !== 1'b0) begin n_fail++; $display("FAIL zs_pass got %b want 0", z_if.pass); end
   endtask

   task automatic test_reset_mid;
      int dc, dn, bc, bl, dseen;
      logic [7:0] v;
      cell_mode = 2'd2;
      @(negedge clk);
      m_if.start = 1'b1;
      @(posedge clk); #1;
      m_if.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;  // cycle 10: SETTLE of vector 2, vector 1 already failed
      n_checks++; if ({m_if.dut_a, m_if.dut_b} !== EXP_ORDER[5:4]) begin n_fail++; $display("FAIL mid_vec2 got %b want %b", {m_if.dut_a, m_if.dut_b}, EXP_ORDER[5:4]); end
      n_checks++; if (m_if.fail_vec !== 4'b0010) begin n_fail++; $display("FAIL mid_partial got %b want 0010", m_if.fail_vec); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_checks++; if ({m_if.busy, m_if.done, m_if.pass} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_flags got %b want 000", {m_if.busy, m_if.done, m_if.pass}); end
      n_checks++; if (m_if.fail_vec !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_fail_vec got %b want 0000", m_if.fail_vec); end
      n_checks++; if ({m_if.dut_a, m_if.dut_b} !== 2'b00) begin n_fail++; $display("FAIL mid_rst_ab got %b want 00", {m_if.dut_a, m_if.dut_b}); end
      dseen = 0;
      for (int c = 0; c < 25; c++) begin
         if (m_if.done || m_if.busy) dseen++;
         @(posedge clk); #1;
      end
      n_checks++; if (dseen !== 0) begin n_fail++; $display("FAIL mid_no_done got %0d active cycles want 0", dseen); end
      cell_mode = 2'd0;
      run_sweep(1'b0, 22, dc, dn, bc, bl, v);
      n_checks++; if (dc !== 17) begin n_fail++; $display("FAIL mid_resweep_cycle got %0d want 17", dc); end
      n_checks++; if (m_if.pass !== 1'b1) begin n_fail++; $display("FAIL mid_resweep_pass got %b want 1", m_if.pass); end
   endtask

   task automatic test_start_ignored;
      int dn, dc, bl;
      cell_mode = 2'd0;
      dn = 0; dc = -1; bl = 0;
      @(negedge clk);
      m_if.start = 1'b1;
      @(posedge clk); #1;
      m_if.start = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         if (m_if.done) begin dn++; if (dc < 0) dc = c; end
         if (m_if.busy) bl = c;
         m_if.start = (c == 5 || c == 10);
         @(posedge clk); #1;
      end
      m_if.start = 1'b0;
      n_checks++; if (dn !== 1 || dc !== 17) begin n_fail++; $display("FAIL ign_done got %0d pulses first %0d want 1 at 17", dn, dc); end
      n_checks++; if (bl !== 17) begin n_fail++; $display("FAIL ign_busy_last got %0d want 17", bl); end
   endtask

   task automatic test_back_to_back;
      int dn, d1, d2;
      cell_mode = 2'd0;
      dn = 0; d1 = -1; d2 = -1;
      @(negedge clk);
      m_if.start = 1'b1;
      @(posedge clk); #1;
      for (int c = 1; c <= 40; c++) begin
         if (m_if.done) begin
            dn++;
            if (d1 < 0) d1 = c;
            else if (d2 < 0) d2 = c;
         end
         @(posedge clk); #1;
      end
      m_if.start = 1'b0;
      n_checks++; if (dn !== 2) begin n_fail++; $display("FAIL b2b_pulses got %0d want 2", dn); end
      n_checks++; if (d1 !== 17 || d2 !== 35) begin n_fail++; $display("FAIL b2b_cycles got %0d,%0d want 17,35", d1, d2); end
      repeat (30) @(posedge clk);
      #1;
      n_checks++; if (m_if.pass !== 1'b1 || m_if.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_final got pass %b busy %b want 1/0", m_if.pass, m_if.busy); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset;
      test_and_pass;
      test_stuck0;
      test_or_cell;
      test_reset_mid;
      test_start_ignored;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
